param_register_file: RTL and testbench

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

---
 rtl/param_register_file.sv | 136 +++++++++++++
 tb/tb_param_register_file.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// Register file with constant read-only entries, two registered read ports and a
// sequenced clear. Define RF_BYPASS_EN to forward accepted write data to a matching read port.
module param_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter logic [(2**ADDR_WIDTH)-1:0] RO_MASK = 8'h61,
  parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] RO_INIT =
    {32'h0000_0000, 32'h3727_C5AC, 32'h4000_0000, 160'h0}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] addr_wr_i,
  input  logic                  WE_i,
  input  logic [ADDR_WIDTH-1:0] addr_rda_i,
  input  logic [ADDR_WIDTH-1:0] addr_rdb_i,
  input  logic                  clr_i,
  output logic [DATA_WIDTH-1:0] RDA_o,
  output logic [DATA_WIDTH-1:0] RDB_o,
  output logic                  busy_o,
  output logic                  wr_drop_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

  logic [0:0]            state_r;
  logic [0:0]            state_nxt_s;
  logic [ADDR_WIDTH-1:0] idx_r;
  logic [ADDR_WIDTH-1:0] idx_nxt_s;
  logic                  wr_accept_s;
  logic                  wr_reject_s;
  logic [DATA_WIDTH-1:0] rd_a_s;
  logic [DATA_WIDTH-1:0] rd_b_s;
  logic [DATA_WIDTH-1:0] entry_s [DEPTH];

  // A write lands only in IDLE, with no clear request, on a writable entry.
  assign wr_accept_s = WE_i & (state_r == IDLE) & ~clr_i & ~RO_MASK[addr_wr_i];
  assign wr_reject_s = WE_i & ~wr_accept_s;

  // Storage: read-only entries are pure constants, writable ones are flops.
  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_entry
      if (RO_MASK[k]) begin : g_ro
        assign entry_s[k] = RO_INIT[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_rw
        localparam logic [ADDR_WIDTH-1:0] MY_IDX = ADDR_WIDTH'(k);
        logic [DATA_WIDTH-1:0] val_r;
        // Entry update: clear sweep and writes are mutually exclusive by state.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            val_r <= '0;
          end else if ((state_r == CLEAR) && (idx_r == MY_IDX)) begin
            val_r <= '0;
          end else if (wr_accept_s && (addr_wr_i == MY_IDX)) begin
            val_r <= data_i;
          end else begin
            val_r <= val_r;
          end
        end
        assign entry_s[k] = val_r;
      end
    end
  endgenerate

  // Clear sequencer next-state: one entry per cycle, stop after the last index.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (clr_i) begin
          state_nxt_s = CLEAR;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
          idx_nxt_s   = idx_r;
        end
      end
      CLEAR: begin
        idx_nxt_s = idx_r + IDX_ONE;
        if (idx_r == LAST_IDX) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // Read mux, optionally forwarding the write accepted in this same cycle.
  always_comb begin
    rd_a_s = entry_s[addr_rda_i];
    rd_b_s = entry_s[addr_rdb_i];
`ifdef RF_BYPASS_EN
    if (wr_accept_s && (addr_wr_i == addr_rda_i)) begin
      rd_a_s = data_i;
    end else begin
      rd_a_s = entry_s[addr_rda_i];
    end
    if (wr_accept_s && (addr_wr_i == addr_rdb_i)) begin
      rd_b_s = data_i;
    end else begin
      rd_b_s = entry_s[addr_rdb_i];
    end
`endif
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      busy_o    <= 1'b0;
      wr_drop_o <= 1'b0;
      RDA_o     <= '0;
      RDB_o     <= '0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      busy_o    <= (state_nxt_s == CLEAR);
      wr_drop_o <= wr_reject_s;
      RDA_o     <= rd_a_s;
      RDB_o     <= rd_b_s;
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: stimulus queues expected outputs,
// a monitor pops and compares them. Honours RF_BYPASS_EN for forwarding expectations.
module tb_param_register_file;

  localparam bit BYP =
`ifdef RF_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_i = 32'h0;
  logic [2:0]  addr_wr_i = 3'd0;
  logic        WE_i = 1'b0;
  logic [2:0]  addr_rda_i = 3'd0;
  logic [2:0]  addr_rdb_i = 3'd0;
  logic        clr_i = 1'b0;
  logic [31:0] RDA_o;
  logic [31:0] RDB_o;
  logic        busy_o;
  logic        wr_drop_o;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  param_register_file dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .addr_wr_i(addr_wr_i), .WE_i(WE_i),
    .addr_rda_i(addr_rda_i), .addr_rdb_i(addr_rdb_i), .clr_i(clr_i),
    .RDA_o(RDA_o), .RDB_o(RDB_o), .busy_o(busy_o), .wr_drop_o(wr_drop_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int kind);
    case (kind)
      0: return "rda";
      1: return "rdb";
      2: return "busy";
      default: return "wr_drop";
    endcase
  endfunction

  task automatic push(input int due, input int kind, input logic [31:0] exp);
    item_t it;
    it.due = due; it.kind = kind; it.exp = exp;
    q.push_back(it);
  endtask

  // One cycle of stimulus; busy/wr_drop expectations refer to the next edge.
  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic we,
                       input logic [2:0] wa, input logic [31:0] wd, input logic clr,
                       input logic e_busy, input logic e_drop);
    @(posedge clk);
    #1;
    addr_rda_i = a; addr_rdb_i = b; WE_i = we; addr_wr_i = wa; data_i = wd; clr_i = clr;
    push(cyc + 1, 2, {31'b0, e_busy});
    push(cyc + 1, 3, {31'b0, e_drop});
  endtask

  task automatic exp_rd(input logic [31:0] ea, input logic [31:0] eb);
    push(cyc + 1, 0, ea);
    push(cyc + 1, 1, eb);
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b, input logic [31:0] ea,
                    input logic [31:0] eb, input logic e_busy);
    drive(a, b, 1'b0, 3'd0, 32'h0, 1'b0, e_busy, 1'b0);
    exp_rd(ea, eb);
  endtask

  task automatic wr(input logic [2:0] wa, input logic [31:0] wd, input logic e_drop);
    drive(3'd0, 3'd0, 1'b1, wa, wd, 1'b0, 1'b0, e_drop);
    exp_rd(32'h0, 32'h0);
  endtask

  // Monitor: compares every queued expectation once its cycle has arrived.
  initial begin
    item_t       it;
    logic [31:0] act;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        it = q.pop_front();
        case (it.kind)
          0: act = RDA_o;
          1: act = RDB_o;
          2: act = {31'b0, busy_o};
          default: act = {31'b0, wr_drop_o};
        endcase
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s got=%h exp=%h cycle=%0d", kname(it.kind), act, it.exp, cyc);
        end
      end
    end
  end

  initial begin
    // Reset state, then release.
    drive(3'd0, 3'd5, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_rd(32'h0, 32'h0);
    drive(3'd0, 3'd0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_rd(32'h0, 32'h0);
    rst_n = 1'b1;

    // Constant image after reset.
    rd(3'd0, 3'd5, 32'h0, 32'h4000_0000, 1'b0);
    rd(3'd5, 3'd6, 32'h4000_0000, 32'h3727_C5AC, 1'b0);
    rd(3'd6, 3'd1, 32'h3727_C5AC, 32'h0, 1'b0);
    rd(3'd1, 3'd0, 32'h0, 32'h0, 1'b0);

    // Write then read; RO write dropped and never forwarded.
    drive(3'd3, 3'd3, 1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    exp_rd(BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0);
    drive(3'd5, 3'd3, 1'b1, 3'd5, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    exp_rd(32'h4000_0000, 32'hDEAD_BEEF);
    rd(3'd5, 3'd3, 32'h4000_0000, 32'hDEAD_BEEF, 1'b0);

    // Same-cycle write/read of entry 2.
    drive(3'd2, 3'd2, 1'b1, 3'd2, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
    exp_rd(BYP ? 32'hA5A5_A5A5 : 32'h0, BYP ? 32'hA5A5_A5A5 : 32'h0);
    rd(3'd2, 3'd0, 32'hA5A5_A5A5, 32'h0, 1'b0);

    // Fill writable entries; entry 0 is read-only.
    wr(3'd1, 32'h1111_1111, 1'b0);
    wr(3'd2, 32'h2222_2222, 1'b0);
    wr(3'd3, 32'h3333_3333, 1'b0);
    wr(3'd4, 32'h4444_4444, 1'b0);
    wr(3'd7, 32'h7777_7777, 1'b0);
    wr(3'd0, 32'hFFFF_FFFF, 1'b1);
    rd(3'd1, 3'd7, 32'h1111_1111, 32'h7777_7777, 1'b0);
    rd(3'd4, 3'd0, 32'h4444_4444, 32'h0, 1'b0);

    // Clear sweep: busy for 8 cycles, reads see not-yet-cleared data.
    drive(3'd1, 3'd7, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0);
    exp_rd(32'h1111_1111, 32'h7777_7777);
    drive(3'd1, 3'd7, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0);
    exp_rd(32'h1111_1111, 32'h7777_7777);
    drive(3'd1, 3'd4, 1'b1, 3'd1, 32'hDEAD_DEAD, 1'b0, 1'b1, 1'b1);
    exp_rd(32'h1111_1111, 32'h4444_4444);
    drive(3'd1, 3'd4, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0);
    exp_rd(32'h0, 32'h4444_4444);
    rd(3'd2, 3'd3, 32'h0, 32'h3333_3333, 1'b1);
    rd(3'd5, 3'd7, 32'h4000_0000, 32'h7777_7777, 1'b1);
    rd(3'd6, 3'd4, 32'h3727_C5AC, 32'h0, 1'b1);
    rd(3'd7, 3'd0, 32'h7777_7777, 32'h0, 1'b1);
    rd(3'd7, 3'd1, 32'h7777_7777, 32'h0, 1'b0);
    rd(3'd7, 3'd3, 32'h0, 32'h0, 1'b0);
    rd(3'd4, 3'd2, 32'h0, 32'h0, 1'b0);
    rd(3'd5, 3'd6, 32'h4000_0000, 32'h3727_C5AC, 1'b0);
    rd(3'd1, 3'd1, 32'h0, 32'h0, 1'b0);

    // Clear and write in the same IDLE cycle: write dropped, clear runs.
    drive(3'd4, 3'd0, 1'b1, 3'd4, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
    exp_rd(32'h0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      rd(3'd4, 3'd0, 32'h0, 32'h0, (i < 8));
    end

    // Reset in the third clear cycle.
    wr(3'd3, 32'h9999_9999, 1'b0);
    drive(3'd3, 3'd5, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0);
    exp_rd(32'h9999_9999, 32'h4000_0000);
    rd(3'd3, 3'd5, 32'h9999_9999, 32'h4000_0000, 1'b1);
    rd(3'd3, 3'd5, 32'h9999_9999, 32'h4000_0000, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #2;
    push(cyc, 2, 32'h0);
    push(cyc, 3, 32'h0);
    push(cyc, 0, 32'h0);
    push(cyc, 1, 32'h0);
    rst_n = 1'b0;
    drive(3'd3, 3'd3, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_rd(32'h0, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rd(3'(i), 3'd7, 32'h0, 32'h0, 1'b0);
    end
    rd(3'd5, 3'd6, 32'h4000_0000, 32'h3727_C5AC, 1'b0);
    wr(3'd4, 32'h0000_ABCD, 1'b0);
    rd(3'd4, 3'd4, 32'h0000_ABCD, 32'h0000_ABCD, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
